// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of {instr, pc}.
// Optional zero-latency bypass when empty is enabled by defining INSTR_BUFFER_BYPASS_EN.
module instr_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [DATA_W-1:0]          fetch_instr,
  input  logic [PC_W-1:0]            fetch_pc,
  output logic                       fetch_ready,
  output logic                       dec_valid,
  output logic [DATA_W-1:0]          dec_instr,
  output logic [PC_W-1:0]            dec_pc,
  input  logic                       dec_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  // DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [PC_W-1:0]   mem_pc    [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic full;
  logic empty;
  logic bypass_take;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Registered-state only; held low while reset is asserted.
  assign fetch_ready = !reset && !full;

`ifdef INSTR_BUFFER_BYPASS_EN
  // Decode consumes the fetch word directly, so it never enters storage.
  assign bypass_take = empty && !flush && !reset && fetch_valid && dec_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = fetch_valid && fetch_ready && !flush && !bypass_take;
  assign pop  = !empty && dec_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= fetch_instr;
      mem_pc[wr_ptr]    <= fetch_pc;
    end
  end

  always_comb begin
    dec_valid = 1'b0;
    dec_instr = '0;
    dec_pc    = '0;
    if (!empty) begin
      dec_valid = 1'b1;
      dec_instr = mem_instr[rd_ptr];
      dec_pc    = mem_pc[rd_ptr];
    end
`ifdef INSTR_BUFFER_BYPASS_EN
    else if (!reset && !flush) begin
      dec_valid = fetch_valid;
      if (fetch_valid) begin
        dec_instr = fetch_instr;
        dec_pc    = fetch_pc;
      end
    end
`endif
  end

endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries; power of two, minimum 2.
REQ-002 SHALL have parameter DATA_W, default 32: instruction word width.
REQ-003 SHALL have parameter PC_W, default 32: program-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port fetch_valid  input  1  fetch stage presents an instruction.
REQ-007 SHALL have port fetch_instr  input  DATA_W  instruction word from fetch.
REQ-008 SHALL have port fetch_pc  input  PC_W  PC of fetch_instr.
REQ-009 SHALL have port fetch_ready  output  1  buffer can accept an instruction this cycle.
REQ-010 SHALL have port dec_valid  output  1  head instruction available to decode.
REQ-011 SHALL have port dec_instr  output  DATA_W  head instruction word.
REQ-012 SHALL have port dec_pc  output  PC_W  PC of the head instruction.
REQ-013 SHALL have port dec_ready  input  1  decode accepts the head instruction.
REQ-014 SHALL have port flush  input  1  redirect; discard all buffered instructions.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL push {fetch_instr, fetch_pc} at the tail on a clock edge where fetch_valid && fetch_ready && !flush.
REQ-017 SHALL pop the head on a clock edge where dec_valid && dec_ready && !flush.
REQ-018 SHALL deliver instructions to decode in strict push order; there SHALL be no drop or duplication.
REQ-019 SHALL drive fetch_ready = (count < DEPTH), from registered state only; it SHALL NOT depend on dec_ready.
REQ-020 SHALL drive dec_valid = (count != 0); dec_instr/dec_pc SHALL show the head entry when dec_valid = 1, and SHALL be 0 otherwise.
REQ-021 Latency: an instruction pushed at edge N SHALL appear at dec outputs after edge N (minimum 1 cycle) when the buffer was empty.
REQ-022 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-024 Full (count = DEPTH): fetch_ready = 0; fetch_valid SHALL be ignored and no state SHALL change from it.
REQ-025 Empty (count = 0): dec_ready SHALL be ignored.
REQ-026 flush SHALL have the highest priority: at the edge, count, rd_ptr and wr_ptr SHALL become 0.
REQ-027 During a flush, any same-cycle push SHALL be discarded.
REQ-028 During a flush, a same-cycle dec handshake SHALL count as consumed by decode; the buffer SHALL still empty.
REQ-029 fetch_ready and dec_valid SHALL hold their REQ-019/REQ-020 values in the flush cycle; flush SHALL take effect on the next cycle.

Reset
REQ-030 While reset = 1: count = 0, pointers = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0, and fetch_ready = 0 (forced low during reset).
REQ-031 On the first cycle after reset deasserts, fetch_ready SHALL be 1.
REQ-032 Storage array contents SHALL NOT require reset.
REQ-033 Reset asserted mid-stream SHALL discard all entries immediately (asynchronously).

Configuration
REQ-034 Macro INSTR_BUFFER_BYPASS_EN defined: when count = 0 and flush = 0, dec_valid SHALL equal fetch_valid, and dec_instr/dec_pc SHALL pass fetch_instr/fetch_pc combinationally.
REQ-035 With INSTR_BUFFER_BYPASS_EN, if dec_ready = 1 in that cycle the instruction SHALL NOT be stored (zero latency).
REQ-036 With INSTR_BUFFER_BYPASS_EN, if dec_ready = 0 in that cycle the instruction SHALL be stored normally.
REQ-037 Macro INSTR_BUFFER_BYPASS_EN undefined: no bypass path; minimum latency SHALL be 1 cycle per REQ-021.

Verification
REQ-038 Reset, then push PCs 0x100, 0x104, 0x108 with dec_ready = 0 -> count = 3, dec_pc = 0x100.
REQ-039 Raise dec_ready -> dec_pc sequence SHALL be 0x100, 0x104, 0x108, then dec_valid = 0.
REQ-040 DEPTH = 8, push 8 with dec_ready = 0 -> fetch_ready = 0, count = 8; a 9th fetch_valid (PC 0x200) SHALL be ignored.
REQ-041 From that full state, pop 1 -> fetch_ready = 1 next cycle.
REQ-042 count = 4 with simultaneous push and pop for 20 cycles -> count stays 4, order preserved, pointers wrap.
REQ-043 count = 5, assert flush with fetch_valid = 1 (PC 0x300) -> next cycle count = 0, dec_valid = 0, PC 0x300 absent afterward.
REQ-044 Assert reset mid-stream at count = 3 -> outputs per REQ-030 immediately.
REQ-045 With INSTR_BUFFER_BYPASS_EN, empty buffer, fetch_valid = 1, dec_ready = 1, PC 0x400 -> dec_pc = 0x400 in the same cycle, and count remains 0.
